// File: rtl/axi_rd_pkg.sv
// Shared types and AXI constants for the read arbiter slice.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } rd_arb_state_t;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the previous winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = 0;
        // Walk offsets 1..NUM_REQ so the previous winner is considered last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master between NUM_REQ requesters, one burst outstanding at a time,
// with sticky per-requester response and protocol error flags.
module axi_read_arbiter
    import axi_rd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int ID_W    = 5
) (
    input  logic                         axis_clk,
    input  logic                         axis_rstn,

    input  logic [NUM_REQ-1:0]           s_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]    s_araddr,
    input  logic [NUM_REQ*8-1:0]         s_arlen,
    output logic [NUM_REQ-1:0]           s_arready,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rlast,
    output logic [NUM_REQ-1:0]           s_rvalid,
    input  logic [NUM_REQ-1:0]           s_rready,

    output logic [ID_W-1:0]              m_axi_arid,
    output logic [ADDR_W-1:0]            m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic [2:0]                   m_axi_arsize,
    output logic [1:0]                   m_axi_arburst,
    output logic                         m_axi_arlock,
    output logic [3:0]                   m_axi_arcache,
    output logic [2:0]                   m_axi_arprot,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [ID_W-1:0]              m_axi_rid,
    input  logic [DATA_W-1:0]            m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,

    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic [NUM_REQ-1:0]           resp_err,
    output logic [NUM_REQ-1:0]           proto_err,
    input  logic                         err_clr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    rd_arb_state_t       state, state_next;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                any_req;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [ID_W-1:0]     ar_id;
    logic [8:0]          beat_cnt;
    logic                accept;
    logic                ar_hs;
    logic                r_hs;
    logic                proto_hit;
    logic [NUM_REQ-1:0]  resp_set;
    logic [NUM_REQ-1:0]  proto_set;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req        (s_arvalid),
        .last_grant (last_grant),
        .grant      (win_onehot),
        .grant_idx  (win_idx),
        .valid      (any_req)
    );

    assign grant_onehot  = NUM_REQ'(1) << grant_idx;
    assign ar_hs         = (state == ST_ADDR) && m_axi_arready;
    assign r_hs          = axis_rstn && (state == ST_DATA) && m_axi_rvalid && s_rready[grant_idx];

    assign m_axi_arid    = ar_id;
    assign m_axi_araddr  = ar_addr;
    assign m_axi_arlen   = ar_len;
    assign m_axi_arsize  = AXI_SIZE_64B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = (state == ST_ADDR);
    assign busy          = (state != ST_IDLE);

    assign s_rdata       = m_axi_rdata;
    assign s_rresp       = m_axi_rresp;
    assign s_rlast       = m_axi_rlast;

    always_ff @(posedge axis_clk) begin
        if (!axis_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs are held at zero while reset is asserted.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        s_arready    = '0;
        s_rvalid     = '0;
        m_axi_rready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    accept     = 1'b1;
                    s_arready  = win_onehot;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                s_rvalid     = grant_onehot & {NUM_REQ{m_axi_rvalid}};
                m_axi_rready = s_rready[grant_idx];
                if (m_axi_rvalid && s_rready[grant_idx] && m_axi_rlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!axis_rstn) begin
            accept       = 1'b0;
            s_arready    = '0;
            s_rvalid     = '0;
            m_axi_rready = 1'b0;
        end
    end

    always_comb begin
        proto_hit = (m_axi_rid != ID_W'(grant_idx))
                 || ( m_axi_rlast && (beat_cnt != {1'b0, ar_len}))
                 || (!m_axi_rlast && (beat_cnt == {1'b0, ar_len}));
        resp_set  = (r_hs && (m_axi_rresp != 2'b00)) ? grant_onehot : '0;
        proto_set = (r_hs && proto_hit) ? grant_onehot : '0;
    end

    // A new error in the same cycle as err_clr survives the clear.
    always_ff @(posedge axis_clk) begin
        if (!axis_rstn) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_idx  <= '0;
            ar_addr    <= '0;
            ar_len     <= '0;
            ar_id      <= '0;
            beat_cnt   <= '0;
            resp_err   <= '0;
            proto_err  <= '0;
        end else begin
            if (accept) begin
                grant_idx <= win_idx;
                ar_addr   <= s_araddr[win_idx*ADDR_W +: ADDR_W];
                ar_len    <= s_arlen[win_idx*8 +: 8];
                ar_id     <= ID_W'(win_idx);
            end
            if (ar_hs) begin
                beat_cnt <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
                if (m_axi_rlast) begin
                    last_grant <= grant_idx;
                end
            end
            resp_err  <= (err_clr ? '0 : resp_err)  | resp_set;
            proto_err <= (err_clr ? '0 : proto_err) | proto_set;
        end
    end

endmodule
